sr_lock_arbiter: RTL and testbench

Round-robin arbiter that shares a bank of NFLAG external SR flip-flops (`sr_flip_flop` instances used as lock/status flags) among NREQ requesters. Each granted request becomes exactly one set pulse, one clear pulse, or none. The block guarantees the bank never sees s=r=1 and that at most one flag is driven per operation. It keeps a registered mirror of the bank contents and returns the pre-operation flag value, so requesters can use it as a test-and-set lock. It sits between the requester logic and the flag bank; the bank's `s`/`r` inputs are driven only by this block.

---
 rtl/sr_lock_arbiter_if.sv | 27 ++
 rtl/sr_lock_arbiter.sv | 138 +++++++++++++
 tb/tb_sr_lock_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sr_lock_arbiter_if.sv
// Requester / flag-bank bundle for sr_lock_arbiter.
// Signal prefixes are from the arbiter's point of view.
interface sr_lock_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
);
  logic [NREQ-1:0]      i_req;
  logic [2*NREQ-1:0]    i_op;
  logic [IDXW*NREQ-1:0] i_idx;
  logic [NREQ-1:0]      o_gnt;
  logic                 o_rdata;
  logic [NFLAG-1:0]     o_s_out;
  logic [NFLAG-1:0]     o_r_out;
  logic [NFLAG-1:0]     o_flags;
  logic                 o_busy;

  modport master (
    output i_req, i_op, i_idx,
    input  o_gnt, o_rdata, o_s_out, o_r_out, o_flags, o_busy
  );

  modport slave (
    input  i_req, i_op, i_idx,
    output o_gnt, o_rdata, o_s_out, o_r_out, o_flags, o_busy
  );
endinterface

// File: rtl/sr_lock_arbiter.sv
// Round-robin arbiter driving a bank of SR flags, with a registered mirror
// of the bank so requesters get the pre-operation value (test-and-set lock).
//
// state  | meaning
// INIT   | r_out all ones for one cycle to clear the bank
// IDLE   | waiting for requests; winner chosen and latched here
// GRANT  | gnt/rdata/s/r pulse visible for one cycle
// SETTLE | bank hold cycle, requests ignored
module sr_lock_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input logic              i_clk,
  input logic              i_rst,
  sr_lock_arbiter_if.slave bus
);
  localparam int PTRW = $clog2(NREQ);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_GRANT, S_SETTLE} state_t;

  state_t           r_state, w_nxt_state;
  logic [PTRW-1:0]  r_ptr, w_nxt_ptr;
  logic [PTRW-1:0]  r_win, w_nxt_win;
  logic [NREQ-1:0]  r_gnt, w_nxt_gnt;
  logic             r_rdata, w_nxt_rdata;
  logic [NFLAG-1:0] r_s, w_nxt_s;
  logic [NFLAG-1:0] r_r, w_nxt_r;
  logic [NFLAG-1:0] r_flags, w_nxt_flags;
  logic             r_busy, w_nxt_busy;

  logic             w_found;
  logic [PTRW-1:0]  w_sel;
  logic [1:0]       w_sel_op;
  logic [IDXW-1:0]  w_sel_idx;

  // Second pass overwrites the first, so a requester at or above the
  // pointer always beats one below it; within a pass the lowest index wins.
  always_comb begin
    w_found   = 1'b0;
    w_sel     = '0;
    w_sel_op  = '0;
    w_sel_idx = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.i_req[j] && (j < int'(r_ptr))) begin
        w_found = 1'b1;
        w_sel   = PTRW'(j);
      end
    end
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.i_req[j] && (j >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_sel   = PTRW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (w_sel == PTRW'(j)) begin
        w_sel_op  = bus.i_op[2*j +: 2];
        w_sel_idx = bus.i_idx[IDXW*j +: IDXW];
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ptr   = r_ptr;
    w_nxt_win   = r_win;
    w_nxt_gnt   = '0;
    w_nxt_rdata = 1'b0;
    w_nxt_s     = '0;
    w_nxt_r     = '0;
    w_nxt_flags = r_flags;
    w_nxt_busy  = 1'b1;
    unique case (r_state)
      S_INIT: begin
        w_nxt_state = S_IDLE;
        w_nxt_busy  = 1'b0;
      end
      S_IDLE: begin
        w_nxt_busy = 1'b0;
        if (w_found) begin
          w_nxt_state = S_GRANT;
          w_nxt_busy  = 1'b1;
          w_nxt_win   = w_sel;
          w_nxt_gnt   = NREQ'(1) << w_sel;
          w_nxt_rdata = r_flags[w_sel_idx];
          unique case (w_sel_op)
            2'b10:   w_nxt_s[w_sel_idx] = 1'b1;
            2'b01:   w_nxt_r[w_sel_idx] = 1'b1;
            2'b11:   w_nxt_s[w_sel_idx] = ~r_flags[w_sel_idx];
            default: ;
          endcase
        end
      end
      S_GRANT: begin
        w_nxt_state = S_SETTLE;
        w_nxt_flags = (r_flags | r_s) & ~r_r;
        w_nxt_ptr   = (r_win == PTRW'(NREQ - 1)) ? '0 : r_win + PTRW'(1);
      end
      S_SETTLE: begin
        w_nxt_state = S_IDLE;
        w_nxt_busy  = 1'b0;
      end
      default: w_nxt_state = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
      r_win   <= '0;
      r_gnt   <= '0;
      r_rdata <= 1'b0;
      r_s     <= '0;
      r_r     <= '1;
      r_flags <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      r_ptr   <= w_nxt_ptr;
      r_win   <= w_nxt_win;
      r_gnt   <= w_nxt_gnt;
      r_rdata <= w_nxt_rdata;
      r_s     <= w_nxt_s;
      r_r     <= w_nxt_r;
      r_flags <= w_nxt_flags;
      r_busy  <= w_nxt_busy;
    end
  end

  assign bus.o_gnt   = r_gnt;
  assign bus.o_rdata = r_rdata;
  assign bus.o_s_out = r_s;
  assign bus.o_r_out = r_r;
  assign bus.o_flags = r_flags;
  assign bus.o_busy  = r_busy;
endmodule

// File: tb/tb_sr_lock_arbiter.sv
// Directed-vector bench for sr_lock_arbiter with an SR bank model and a
// per-cycle invariant monitor, followed by a randomized model comparison.
module tb_sr_lock_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic [7:0] bank = 8'hA5;

  sr_lock_arbiter_if #(.NREQ(4), .NFLAG(8), .IDXW(3)) bus ();

  sr_lock_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural SR flip-flop bank, driven only by the arbiter.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (bus.o_s_out[i])      bank[i] <= 1'b1;
      else if (bus.o_r_out[i]) bank[i] <= 1'b0;
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  op;
    logic [11:0] idx;
    logic [3:0]  gnt;
    logic        rdata;
    logic [7:0]  s;
    logic [7:0]  r;
    logic [7:0]  flags;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv_s_and_r", 32'(bus.o_s_out & bus.o_r_out), 32'd0);
      chk("inv_sr_onehot", 32'($countones(bus.o_s_out | bus.o_r_out) <= 1), 32'd1);
      chk("inv_gnt_onehot", 32'($countones(bus.o_gnt) <= 1), 32'd1);
      chk("bank_mirror", 32'(bus.o_flags), 32'(bank));
    end
  end

  // Starts at an IDLE negedge, ends at the next IDLE negedge.
  task automatic run_op(input string tag, input logic [3:0] req, input logic [7:0] op,
                        input logic [11:0] idx, input logic [3:0] gnt, input logic rdata,
                        input logic [7:0] s, input logic [7:0] r, input logic [7:0] flags);
    bus.i_req = req;
    bus.i_op  = op;
    bus.i_idx = idx;
    @(negedge clk);
    chk({tag, "_gnt"},   32'(bus.o_gnt),   32'(gnt));
    chk({tag, "_rdata"}, 32'(bus.o_rdata), 32'(rdata));
    chk({tag, "_s"},     32'(bus.o_s_out), 32'(s));
    chk({tag, "_r"},     32'(bus.o_r_out), 32'(r));
    chk({tag, "_busy"},  32'(bus.o_busy),  32'd1);
    bus.i_req = '0;
    @(negedge clk);
    chk({tag, "_flags"},      32'(bus.o_flags), 32'(flags));
    chk({tag, "_settle_gnt"}, 32'(bus.o_gnt),   32'd0);
    chk({tag, "_settle_sr"},  32'(bus.o_s_out | bus.o_r_out), 32'd0);
    @(negedge clk);
    chk({tag, "_idle_busy"},  32'(bus.o_busy),  32'd0);
  endtask

  logic [7:0] mflags;
  int         mptr;

  initial begin
    bus.i_req = '0;
    bus.i_op  = '0;
    bus.i_idx = '0;

    // requester fields packed {3,2,1,0}
    vecs[0]  = '{req:4'b0001, op:{2'b00,2'b00,2'b00,2'b10}, idx:{3'd0,3'd0,3'd0,3'd5}, gnt:4'b0001, rdata:1'b0, s:8'h20, r:8'h00, flags:8'h20};
    vecs[1]  = '{req:4'b0001, op:{2'b00,2'b00,2'b00,2'b01}, idx:{3'd0,3'd0,3'd0,3'd5}, gnt:4'b0001, rdata:1'b1, s:8'h00, r:8'h20, flags:8'h00};
    vecs[2]  = '{req:4'b1000, op:{2'b10,2'b00,2'b00,2'b00}, idx:{3'd0,3'd0,3'd0,3'd0}, gnt:4'b1000, rdata:1'b0, s:8'h01, r:8'h00, flags:8'h01};
    vecs[3]  = '{req:4'b0110, op:{2'b00,2'b11,2'b11,2'b00}, idx:{3'd0,3'd3,3'd3,3'd0}, gnt:4'b0010, rdata:1'b0, s:8'h08, r:8'h00, flags:8'h09};
    vecs[4]  = '{req:4'b0110, op:{2'b00,2'b11,2'b11,2'b00}, idx:{3'd0,3'd3,3'd3,3'd0}, gnt:4'b0100, rdata:1'b1, s:8'h00, r:8'h00, flags:8'h09};
    vecs[5]  = '{req:4'b0001, op:{2'b00,2'b00,2'b00,2'b00}, idx:{3'd0,3'd0,3'd0,3'd3}, gnt:4'b0001, rdata:1'b1, s:8'h00, r:8'h00, flags:8'h09};
    vecs[6]  = '{req:4'b1001, op:{2'b10,2'b00,2'b00,2'b01}, idx:{3'd7,3'd0,3'd0,3'd0}, gnt:4'b1000, rdata:1'b0, s:8'h80, r:8'h00, flags:8'h89};
    vecs[7]  = '{req:4'b1001, op:{2'b10,2'b00,2'b00,2'b01}, idx:{3'd7,3'd0,3'd0,3'd0}, gnt:4'b0001, rdata:1'b1, s:8'h00, r:8'h01, flags:8'h88};
    vecs[8]  = '{req:4'b0100, op:{2'b00,2'b11,2'b00,2'b00}, idx:{3'd0,3'd7,3'd0,3'd0}, gnt:4'b0100, rdata:1'b1, s:8'h00, r:8'h00, flags:8'h88};
    vecs[9]  = '{req:4'b0010, op:{2'b00,2'b00,2'b01,2'b00}, idx:{3'd0,3'd0,3'd3,3'd0}, gnt:4'b0010, rdata:1'b1, s:8'h00, r:8'h08, flags:8'h80};
    vecs[10] = '{req:4'b1000, op:{2'b00,2'b00,2'b00,2'b00}, idx:{3'd0,3'd0,3'd0,3'd0}, gnt:4'b1000, rdata:1'b0, s:8'h00, r:8'h00, flags:8'h80};

    // Reset and INIT
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",   32'(bus.o_gnt),   32'd0);
    chk("rst_rdata", 32'(bus.o_rdata), 32'd0);
    chk("rst_s",     32'(bus.o_s_out), 32'd0);
    chk("rst_r",     32'(bus.o_r_out), 32'hFF);
    chk("rst_flags", 32'(bus.o_flags), 32'd0);
    chk("rst_busy",  32'(bus.o_busy),  32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_r",    32'(bus.o_r_out), 32'hFF);
    chk("init_busy", 32'(bus.o_busy),  32'd1);
    @(negedge clk);
    chk("idle_r",     32'(bus.o_r_out), 32'd0);
    chk("idle_s",     32'(bus.o_s_out), 32'd0);
    chk("idle_flags", 32'(bus.o_flags), 32'd0);
    chk("idle_busy",  32'(bus.o_busy),  32'd0);
    chk("idle_gnt",   32'(bus.o_gnt),   32'd0);
    chk("bank_clear", 32'(bank),        32'd0);
    mon_en = 1'b1;

    for (int v = 0; v < 11; v++)
      run_op($sformatf("vec%0d", v), vecs[v].req, vecs[v].op, vecs[v].idx,
             vecs[v].gnt, vecs[v].rdata, vecs[v].s, vecs[v].r, vecs[v].flags);

    // Round robin under continuous requests, pointer at 0
    bus.i_req = 4'b1111;
    bus.i_op  = '0;
    bus.i_idx = '0;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_gnt", g), 32'(bus.o_gnt), 32'(4'b0001 << (g % 4)));
      chk($sformatf("rr%0d_sr", g), 32'(bus.o_s_out | bus.o_r_out), 32'd0);
      @(negedge clk);
      chk($sformatf("rr%0d_settle", g), 32'(bus.o_gnt), 32'd0);
      @(negedge clk);
      chk($sformatf("rr%0d_idle", g), 32'(bus.o_gnt), 32'd0);
    end
    bus.i_req = '0;

    // Reset during GRANT of a set to idx 7 (pointer 1, only req0)
    bus.i_req = 4'b0001;
    bus.i_op  = {2'b00, 2'b00, 2'b00, 2'b10};
    bus.i_idx = {3'd0, 3'd0, 3'd0, 3'd7};
    @(negedge clk);
    chk("mid_gnt", 32'(bus.o_gnt),   32'b0001);
    chk("mid_s",   32'(bus.o_s_out), 32'h80);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_gnt",   32'(bus.o_gnt),   32'd0);
    chk("mid_rst_s",     32'(bus.o_s_out), 32'd0);
    chk("mid_rst_r",     32'(bus.o_r_out), 32'hFF);
    chk("mid_rst_flags", 32'(bus.o_flags), 32'd0);
    chk("mid_rst_busy",  32'(bus.o_busy),  32'd1);
    bus.i_req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_init_r", 32'(bus.o_r_out), 32'hFF);
    @(negedge clk);
    chk("mid_idle_r",     32'(bus.o_r_out), 32'd0);
    chk("mid_idle_flags", 32'(bus.o_flags), 32'd0);
    chk("mid_idle_bank",  32'(bank),        32'd0);
    chk("mid_idle_busy",  32'(bus.o_busy),  32'd0);
    mon_en = 1'b1;

    // Randomized traffic against a reference model
    mflags = '0;
    mptr   = 0;
    for (int n = 0; n < 2000; n++) begin
      logic [3:0]  rq;
      logic [7:0]  rop;
      logic [11:0] ridx;
      logic [3:0]  eg;
      logic        erd;
      logic [7:0]  es, er;
      int          w;
      logic [1:0]  wop;
      logic [2:0]  wix;
      rq   = 4'($urandom_range(0, 15));
      rop  = 8'($urandom);
      ridx = 12'($urandom);
      if (rq == 4'd0) begin
        bus.i_req = rq;
        @(negedge clk);
        chk("rnd_nogrant", 32'(bus.o_gnt), 32'd0);
        chk("rnd_nobusy",  32'(bus.o_busy), 32'd0);
        continue;
      end
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && rq[(mptr + k) % 4]) w = (mptr + k) % 4;
      wop = rop[2*w +: 2];
      wix = ridx[3*w +: 3];
      eg  = 4'b0001 << w;
      erd = mflags[wix];
      es  = '0;
      er  = '0;
      if (wop == 2'b10 || (wop == 2'b11 && !mflags[wix])) es[wix] = 1'b1;
      if (wop == 2'b01) er[wix] = 1'b1;
      mflags = (mflags | es) & ~er;
      mptr   = (w + 1) % 4;
      run_op("rnd", rq, rop, ridx, eg, erd, es, er, mflags);
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
